// File: rtl/imem_boot_loader_if.sv
// Byte-stream/IMEM-write bundle between the boot-loader and its stream source and core side.
// master drives start and the byte stream; slave is the loader itself.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  start;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_rst;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Serial byte-stream IMEM loader: length header + LE 32-bit words, holds the core in reset while busy.
// Optional CHECKSUM_EN: trailing XOR checksum byte over length and data, mismatch ends in err.
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input logic              clk,
  input logic              rst,
  imem_boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
`ifdef CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

`ifdef CHECKSUM_EN
  localparam state_t FINAL = CSUM;
`else
  localparam state_t FINAL = DONE;
`endif

  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

  state_t                state, state_next;
  logic [15:0]           len;
  logic [15:0]           len_full;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [23:0]           word;
  logic [31:0]           word_full;
  logic                  accept;
  logic                  go;
  logic                  last_word;
  logic                  rx_ready;
  logic                  busy;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
`ifdef CHECKSUM_EN
  logic [7:0]            csum;
`endif

  assign accept    = bus.rx_valid & rx_ready;
  assign go        = bus.start & (state == IDLE || state == DONE || state == ERR);
  assign len_full  = {bus.rx_data, len[7:0]};
  assign word_full = {bus.rx_data, word};
  assign last_word = (17'(idx) + 17'd1) == {1'b0, len};

  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    unique case (state)
      LEN0, LEN1, DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: busy = 1'b1;
`ifdef CHECKSUM_EN
      CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE, ERR: if (go) state_next = LEN0;
      LEN0: if (accept) state_next = LEN1;
      LEN1: if (accept) begin
        if ({1'b0, len_full} > CAP) state_next = ERR;
        else if (len_full == 16'd0)  state_next = FINAL;
        else                         state_next = DATA;
      end
      DATA: if (accept && byte_cnt == 2'd3) state_next = WRITE;
      WRITE: state_next = last_word ? FINAL : DATA;
`ifdef CHECKSUM_EN
      CSUM: if (accept) state_next = (bus.rx_data == csum) ? DONE : ERR;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      byte_cnt <= '0;
      idx      <= '0;
      word     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state <= state_next;
      we_q  <= 1'b0;
      if (go) begin
        byte_cnt <= '0;
        idx      <= '0;
      end
      unique case (state)
        LEN0: if (accept) len[7:0]  <= bus.rx_data;
        LEN1: if (accept) len[15:8] <= bus.rx_data;
        DATA: if (accept) begin
          word     <= word_full[31:8];
          byte_cnt <= byte_cnt + 2'd1;
          // Word is registered on the 4th byte so the strobe lands in WRITE.
          if (byte_cnt == 2'd3) begin
            we_q    <= 1'b1;
            addr_q  <= idx;
            wdata_q <= word_full;
          end
        end
        WRITE: idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)                          csum <= '0;
    else if (go)                      csum <= '0;
    else if (accept && state != CSUM) csum <= csum ^ bus.rx_data;
  end
`endif

  assign bus.rx_ready   = rx_ready;
  assign bus.busy       = busy;
  assign bus.cpu_rst    = rst | busy;
  assign bus.done       = (state == DONE);
  assign bus.err        = (state == ERR);
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: randomized images, expected writes queued, monitor compares.
// Works with or without CHECKSUM_EN defined.
module tb_imem_boot_loader;
  localparam int unsigned AW  = 4;
  localparam int unsigned CAP = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();
  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          passed = 0;
  int          total  = 0;
  int          stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops expected writes and counts not-ready cycles while busy.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.busy && !bus.rx_ready) stall_cnt++;
      if (bus.imem_we) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: addr %0h data %08h with empty queue",
                   bus.imem_addr, bus.imem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(bus.imem_addr), 64'(e.addr));
          chk("wr_data", 64'(bus.imem_wdata), 64'(e.data));
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Presents one byte from a negedge and returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b, input bit hold, input bit glitch);
    int t;
    if (!hold && $urandom_range(0, 2) == 0) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (glitch) bus.start = 1'b1;
    t = 0;
    while (!bus.rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      total++;
      $display("FAIL rx_ready_timeout: byte %02h never accepted", b);
    end
    @(negedge clk);
    bus.start = 1'b0;
    if (!hold) bus.rx_valid = 1'b0;
  endtask

  // Reference: image of n words from img[], optional trailing XOR checksum.
  task automatic run_load(input int n, input bit bad_csum, input bit hold, input bit glitch);
    logic [7:0]  bytes[$];
    logic [7:0]  x;
    logic [15:0] nn;
    bit          exp_err;
    int          t;
    wr_t         e;
    nn = 16'(n);
    bytes.push_back(nn[7:0]);
    bytes.push_back(nn[15:8]);
    exp_err = (n > CAP);
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) bytes.push_back(8'(img[i] >> (8 * k)));
        e.addr = AW'(i);
        e.data = img[i];
        exp_q.push_back(e);
      end
`ifdef CHECKSUM_EN
      x = 8'h00;
      foreach (bytes[i]) x ^= bytes[i];
      bytes.push_back(bad_csum ? (x ^ 8'h01) : x);
      exp_err = bad_csum;
`endif
    end
    pulse_start();
    stall_cnt = 0;
    foreach (bytes[i]) send(bytes[i], hold, glitch && i == 4);
    bus.rx_valid = 1'b0;
    t = 0;
    while (!(bus.done || bus.err) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("load_done", 64'(bus.done), 64'(!exp_err));
    chk("load_err", 64'(bus.err), 64'(exp_err));
    chk("busy_after", 64'(bus.busy), 64'd0);
    chk("cpu_rst_after", 64'(bus.cpu_rst), 64'd0);
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    chk("stall_cycles", 64'(stall_cnt), 64'(n > CAP ? 0 : n));
    x = 8'h00;
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  initial begin
    wr_t e;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cpu_rst", 64'(bus.cpu_rst), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("rst_we", 64'(bus.imem_we), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cpu_rst", 64'(bus.cpu_rst), 64'd0);

    // Reference program image, then oversize length, then empty image.
    img = '{32'h00100513, 32'h0000006F};
    run_load(2, 1'b0, 1'b0, 1'b0);
    run_load(CAP + 1, 1'b0, 1'b0, 1'b0);
    run_load(0, 1'b0, 1'b0, 1'b0);
`ifdef CHECKSUM_EN
    img = '{32'h00100513, 32'h0000006F};
    run_load(2, 1'b1, 1'b0, 1'b0);
    run_load(2, 1'b0, 1'b0, 1'b0);
`endif

    // Reset after the length and first word: only word 0 is written.
    img = '{32'h00100513, 32'h0000006F};
    e.addr = '0;
    e.data = img[0];
    exp_q.push_back(e);
    pulse_start();
    send(8'h02, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send(8'h13, 1'b0, 1'b0);
    send(8'h05, 1'b0, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_cpu_rst", 64'(bus.cpu_rst), 64'd1);
    chk("midrst_done_err", 64'({bus.done, bus.err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release", 64'(bus.cpu_rst), 64'd0);
    chk("midrst_writes", 64'(exp_q.size()), 64'd0);
    run_load(2, 1'b0, 1'b0, 1'b0);

    // Continuous rx_valid with a start pulse during DATA, then full capacity.
    rand_img(3);
    run_load(3, 1'b0, 1'b1, 1'b1);
    rand_img(CAP);
    run_load(CAP, 1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 10; r++) begin
      int n;
      n = int'($urandom_range(0, CAP + 2));
      rand_img(n);
`ifdef CHECKSUM_EN
      run_load(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
      run_load(n, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`endif
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
